gcd_share_ctrl: RTL and testbench
=================================

Name: gcd_share_ctrl

Overview:
Round-robin scheduler that shares one subtractive GCD engine (datapath plus its controller) among NREQ requesters. It arbitrates requests and latches the winner's operand pair. It feeds the pair to the engine as a start pulse followed by a two-cycle serial load (A then B) on a shared data bus. It then waits for the engine's done, with a watchdog, and returns the result to the granted requester. Zero operands are resolved locally without using the engine.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 16, operand/result width
TIMEOUT, 1023, max WAIT cycles before abort (counter width = clog2(TIMEOUT+1))

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request level
req_a  in  NREQ*W  operand A, requester i at [i*W +: W]
req_b  in  NREQ*W  operand B, same packing
ack  out  NREQ  one-cycle pulse: request i accepted, operands latched
resp_valid  out  NREQ  one-cycle pulse: result for requester i on resp_data/resp_err
resp_data  out  W  result, shared bus
resp_err  out  1  qualifies resp_valid: 1 = both operands zero or timeout
busy  out  1  high in every state except IDLE
eng_start  out  1  engine start pulse
eng_data  out  W  engine data_in bus
eng_done  in  1  engine done level
eng_result  in  W  engine A-register output (valid when eng_done)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ack, resp_valid, resp_err, busy, eng_start = 0; resp_data, eng_data = 0; RR pointer = 0 (requester 0 highest priority); timer = 0. Reset mid-operation aborts silently with no response. The engine is reset independently.
- All outputs are registered.
- IDLE: at a clock edge with any req bit high, grant = first set bit at or after pointer, wrapping modulo NREQ. Latch req_a/req_b of the grant. ack[grant] is high in the next cycle.
  - If A==0 or B==0: go to RESP with result = A|B; err=1 only if both are zero. eng_start is never asserted.
  - Otherwise go to LOAD_A.
- LOAD_A (1 cycle): eng_start=1, eng_data=A. Next state LOAD_B.
- LOAD_B (1 cycle): eng_start=0, eng_data=B. Timer cleared. Next state WAIT.
- WAIT: eng_data holds B. Timer increments each cycle.
  - eng_done is ignored in the first WAIT cycle (stale done from the previous run).
  - From the second WAIT cycle, eng_done=1 captures eng_result and goes to RESP with err=0.
  - If the timer reaches TIMEOUT with no done, go to RESP with result=0, err=1.
  - If done and timeout occur in the same cycle, done wins.
- RESP (1 cycle): resp_valid[grant]=1, resp_data and resp_err driven.
  - Pointer = grant+1 mod NREQ.
  - Next state IDLE, where a new arbitration happens at the same edge that leaves RESP.
  - resp_data/resp_err hold their last value until the next RESP.
- Requester rules: hold req and operands stable until ack, then drop req. A req still high at the IDLE sample after resp is treated as a new request. Changes to req during non-IDLE states are ignored.
- Latency, nonzero operands: ack at T+1, eng_start at T+1, B on eng_data at T+2, resp_valid 1 cycle after the captured done.
- Latency, zero bypass: ack at T+1 (RESP state), resp_valid at T+1 (same cycle as ack).
- At most one ack bit and one resp_valid bit are high at any time.

Decomposition:
- gcd_pkg: state encoding (IDLE, LOAD_A, LOAD_B, WAIT, RESP as a 3-bit localparam set), default W.
- Sub-module rr_arbiter: parameter NREQ. Inputs req and pointer; output one-hot grant plus index. Purely combinational; the pointer register stays in gcd_share_ctrl.

Test Plan:
1. Single request: req[0]=1, A=143, B=78, engine attached → ack[0] at T+1; eng_data 143 then 78; resp_valid[0] with resp_data=13, resp_err=0.
2. Simultaneous requests: req[1] (36,24) and req[2] (17,5) raised together with pointer=0 → requester 1 served first (12), then requester 2 (1); never two ack bits high.
3. Fairness: all four req held continuously, each re-raised after its resp → grant order 0,1,2,3,0,1… with no starvation over 12 transactions.
4. Zero bypass: req[3] with (0,36) → resp_data=36, err=0, eng_start never asserted; (0,0) → resp_data=0, err=1.
5. Timeout: eng_done tied 0, TIMEOUT=15, req (10,4) → resp_err=1, resp_data=0 exactly 15 WAIT cycles after LOAD_B; busy then drops.
6. Reset mid-run: rst_n pulsed low during WAIT → all outputs 0 immediately, no resp_valid; a following req[2] is served with pointer reset to 0.

Source files
------------

// File: rtl/gcd_share_ctrl_pkg.sv
// Shared types for the GCD engine sharing controller: FSM encoding, default
// width and the round-robin pointer increment.
package gcd_share_ctrl_pkg;

    localparam int DEF_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/gcd_share_ctrl_if.sv
// Requester and engine signal bundle. Requester handshake: req/operands are held
// until the one-cycle ack pulse; the result comes back as a one-cycle resp_valid.
interface gcd_share_ctrl_if #(
    parameter int NREQ = 4,
    parameter int W    = 16
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   resp_valid;
    logic [W-1:0]      resp_data;
    logic              resp_err;
    logic              eng_start;
    logic [W-1:0]      eng_data;
    logic              eng_done;
    logic [W-1:0]      eng_result;

    modport master (
        output req, req_a, req_b, eng_done, eng_result,
        input  ack, resp_valid, resp_data, resp_err, eng_start, eng_data
    );

    modport slave (
        input  req, req_a, req_b, eng_done, eng_result,
        output ack, resp_valid, resp_data, resp_err, eng_start, eng_data
    );
endinterface

// File: rtl/gcd_share_ctrl_arb.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDXW-1:0] idx_o
);
    logic            found;
    logic [IDXW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDXW'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end
endmodule

// File: rtl/gcd_share_ctrl.sv
// Shares one subtractive GCD engine among NREQ requesters: arbitrate, serially
// load A then B, wait for done under a watchdog, return the result.
module gcd_share_ctrl
    import gcd_share_ctrl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    gcd_share_ctrl_if.slave     bus,
    output logic                busy_o,
    output state_e              dbg_state_o
);
    localparam int IDXW = $clog2(NREQ);
    localparam int TW   = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] grant_q, grant_d;
    logic [W-1:0]    b_q, b_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic [W-1:0]    resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;
    logic            busy_q, busy_d;
    logic            eng_start_q, eng_start_d;
    logic [W-1:0]    eng_data_q, eng_data_d;

    logic [NREQ-1:0] arb_grant;
    logic [IDXW-1:0] arb_idx;
    logic [W-1:0]    sel_a, sel_b;
    logic [NREQ-1:0] resp_hot;

    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    assign sel_a = bus.req_a[arb_idx*W +: W];
    assign sel_b = bus.req_b[arb_idx*W +: W];

    // The pointer advances at grant time; every grant either reaches RESP or is
    // wiped by reset, so this matches advancing it on the way out of RESP.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        b_d          = b_q;
        timer_d      = timer_q;
        ack_d        = '0;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        eng_start_d  = 1'b0;
        eng_data_d   = eng_data_q;
        resp_hot     = '0;
        resp_hot[grant_q] = 1'b1;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (|bus.req) begin
                    grant_d = arb_idx;
                    ptr_d   = IDXW'(rr_next(int'(arb_idx), NREQ));
                    b_d     = sel_b;
                    ack_d   = arb_grant;
                    if (sel_a == '0 || sel_b == '0) begin
                        state_d      = ST_RESP;
                        resp_valid_d = arb_grant;
                        resp_data_d  = sel_a | sel_b;
                        resp_err_d   = ((sel_a | sel_b) == '0);
                    end else begin
                        state_d     = ST_LOAD_A;
                        eng_start_d = 1'b1;
                        eng_data_d  = sel_a;
                    end
                end
            end
            ST_LOAD_A: begin
                state_d    = ST_LOAD_B;
                eng_data_d = b_q;
            end
            ST_LOAD_B: begin
                state_d = ST_WAIT;
                timer_d = '0;
            end
            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                // timer_q == 0 marks the first WAIT cycle, where done is stale
                if (timer_q != '0 && bus.eng_done) begin
                    state_d      = ST_RESP;
                    resp_valid_d = resp_hot;
                    resp_data_d  = bus.eng_result;
                    resp_err_d   = 1'b0;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d      = ST_RESP;
                    resp_valid_d = resp_hot;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            b_q          <= '0;
            timer_q      <= '0;
            ack_q        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            b_q          <= b_d;
            timer_q      <= timer_d;
            ack_q        <= ack_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
            eng_start_q  <= eng_start_d;
            eng_data_q   <= eng_data_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.eng_start  = eng_start_q;
    assign bus.eng_data   = eng_data_q;
    assign busy_o         = busy_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_gcd_share_ctrl.sv
// Directed bench for gcd_share_ctrl with a behavioural subtractive GCD engine.
module tb_gcd_share_ctrl;
    import gcd_share_ctrl_pkg::*;

    logic   clk;
    logic   rst_n;
    logic   busy;
    state_e dbg_state;
    logic   eng_en;

    int n_checks;
    int n_fail;

    gcd_share_ctrl_if #(.NREQ(4), .W(16)) bus ();

    gcd_share_ctrl #(.NREQ(4), .W(16), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy_o      (busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- engine model ----------------
    // start edge takes A, next edge takes B, then one subtraction per cycle;
    // done stays high after finishing until the first compute step of the next run.
    logic [15:0] ea = '0;
    logic [15:0] eb = '0;
    int          eph = 0;
    initial bus.eng_done = 1'b0;
    assign bus.eng_result = ea;

    always @(posedge clk) begin
        if (bus.eng_start) begin
            ea  <= bus.eng_data;
            eph <= 1;
        end else if (eph == 1) begin
            eb  <= bus.eng_data;
            eph <= 2;
        end else if (eph == 2) begin
            if (ea == eb) begin
                bus.eng_done <= eng_en;
                eph          <= 0;
            end else begin
                bus.eng_done <= 1'b0;
                if (ea > eb) ea <= ea - eb;
                else         eb <= eb - ea;
            end
        end
    end

    // ---------------- driver helpers ----------------
    int          ack_log [16];
    int          rsp_idx [16];
    logic [15:0] rsp_dat [16];
    logic        rsp_err [16];
    int          n_ack, n_rsp, n_multi;

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[i*16 +: 16] = a;
        bus.req_b[i*16 +: 16] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drops req on ack; optionally re-raises it after the matching response.
    task automatic serve(input int max_tx, input logic rearm, input int budget);
        n_ack = 0; n_rsp = 0; n_multi = 0;
        for (int k = 0; k < 16; k++) begin
            ack_log[k] = -1; rsp_idx[k] = -1; rsp_dat[k] = '1; rsp_err[k] = 1'bx;
        end
        for (int c = 0; c < budget && n_rsp < max_tx; c++) begin
            @(negedge clk);
            if ($countones(bus.ack) > 1 || $countones(bus.resp_valid) > 1) n_multi++;
            for (int i = 0; i < 4; i++) begin
                if (bus.ack[i] && n_ack < 16) begin
                    ack_log[n_ack] = i; n_ack++; bus.req[i] = 1'b0;
                end
                if (bus.resp_valid[i] && n_rsp < 16) begin
                    rsp_idx[n_rsp] = i; rsp_dat[n_rsp] = bus.resp_data;
                    rsp_err[n_rsp] = bus.resp_err; n_rsp++;
                    if (rearm && n_rsp < max_tx) bus.req[i] = 1'b1;
                end
            end
        end
        bus.req = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_checks++; if (bus.ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", bus.ack); end
        n_checks++; if (bus.resp_valid !== 4'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0000", bus.resp_valid); end
        n_checks++; if ({busy, bus.eng_start, bus.resp_err} !== 3'b0) begin n_fail++; $display("FAIL reset_flags: busy/start/err got %b want 000", {busy, bus.eng_start, bus.resp_err}); end
        n_checks++; if ({bus.resp_data, bus.eng_data} !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {bus.resp_data, bus.eng_data}); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic got, prev_done;
        set_ops(0, 16'd143, 16'd78);
        bus.req[0] = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b want 0001", bus.ack); end
        n_checks++; if (bus.eng_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", bus.eng_start); end
        n_checks++; if (bus.eng_data !== 16'd143) begin n_fail++; $display("FAIL single_data_a: got %0d want 143", bus.eng_data); end
        bus.req[0] = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.eng_start, bus.eng_data} !== {1'b0, 16'd78}) begin n_fail++; $display("FAIL single_data_b: start %b data %0d want 0/78", bus.eng_start, bus.eng_data); end
        got = 1'b0; prev_done = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (bus.resp_valid != 4'b0) got = 1'b1;
            else prev_done = bus.eng_done;
        end
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL single_timeout: no resp_valid within 40 cycles"); end
        n_checks++; if (bus.resp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_resp_valid: got %b want 0001", bus.resp_valid); end
        n_checks++; if ({bus.resp_err, bus.resp_data} !== {1'b0, 16'd13}) begin n_fail++; $display("FAIL single_result: err %b data %0d want 0/13", bus.resp_err, bus.resp_data); end
        n_checks++; if (prev_done !== 1'b1) begin n_fail++; $display("FAIL single_latency: done before resp got %b want 1", prev_done); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b want 0", busy); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_ops(1, 16'd36, 16'd24);
        set_ops(2, 16'd17, 16'd5);
        bus.req = 4'b0110;
        serve(2, 1'b0, 100);
        n_checks++; if (n_rsp !== 2) begin n_fail++; $display("FAIL simul_count: got %0d responses want 2", n_rsp); end
        n_checks++; if (ack_log[0] !== 1 || ack_log[1] !== 2) begin n_fail++; $display("FAIL simul_ack_order: got %0d,%0d want 1,2", ack_log[0], ack_log[1]); end
        n_checks++; if (rsp_idx[0] !== 1 || rsp_dat[0] !== 16'd12 || rsp_err[0] !== 1'b0) begin n_fail++; $display("FAIL simul_resp0: idx %0d data %0d err %b want 1/12/0", rsp_idx[0], rsp_dat[0], rsp_err[0]); end
        n_checks++; if (rsp_idx[1] !== 2 || rsp_dat[1] !== 16'd1 || rsp_err[1] !== 1'b0) begin n_fail++; $display("FAIL simul_resp1: idx %0d data %0d err %b want 2/1/0", rsp_idx[1], rsp_dat[1], rsp_err[1]); end
        n_checks++; if (n_multi !== 0) begin n_fail++; $display("FAIL simul_onehot: %0d cycles with multiple ack/resp bits, want 0", n_multi); end
    endtask

    task automatic test_fairness();
        logic [15:0] exp_g [4];
        exp_g[0] = 16'd4; exp_g[1] = 16'd3; exp_g[2] = 16'd7; exp_g[3] = 16'd5;
        do_reset();
        set_ops(0, 16'd12, 16'd8);
        set_ops(1, 16'd9,  16'd6);
        set_ops(2, 16'd21, 16'd14);
        set_ops(3, 16'd25, 16'd15);
        bus.req = 4'b1111;
        serve(12, 1'b1, 400);
        n_checks++; if (n_rsp !== 12) begin n_fail++; $display("FAIL fair_count: got %0d responses want 12", n_rsp); end
        for (int k = 0; k < 12; k++) begin
            n_checks++;
            if (rsp_idx[k] !== k % 4 || rsp_dat[k] !== exp_g[k % 4] || rsp_err[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL fair_tx%0d: idx %0d data %0d err %b want %0d/%0d/0", k, rsp_idx[k], rsp_dat[k], rsp_err[k], k % 4, exp_g[k % 4]);
            end
        end
        n_checks++; if (n_multi !== 0) begin n_fail++; $display("FAIL fair_onehot: %0d cycles with multiple ack/resp bits, want 0", n_multi); end
    endtask

    task automatic test_zero_bypass();
        @(negedge clk);
        set_ops(3, 16'd0, 16'd36);
        bus.req[3] = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.ack, bus.resp_valid} !== 8'b1000_1000) begin n_fail++; $display("FAIL zero_ack_resp: ack %b resp %b want 1000/1000", bus.ack, bus.resp_valid); end
        n_checks++; if ({bus.resp_err, bus.resp_data} !== {1'b0, 16'd36}) begin n_fail++; $display("FAIL zero_result: err %b data %0d want 0/36", bus.resp_err, bus.resp_data); end
        n_checks++; if (bus.eng_start !== 1'b0) begin n_fail++; $display("FAIL zero_no_start: got %b want 0", bus.eng_start); end
        bus.req[3] = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, bus.eng_start, bus.resp_valid} !== 6'b0) begin n_fail++; $display("FAIL zero_idle: busy %b start %b resp %b want 0", busy, bus.eng_start, bus.resp_valid); end
        n_checks++; if (bus.resp_data !== 16'd36) begin n_fail++; $display("FAIL zero_hold: got %0d want 36", bus.resp_data); end
        set_ops(3, 16'd0, 16'd0);
        bus.req[3] = 1'b1;
        @(negedge clk);
        bus.req[3] = 1'b0;
        n_checks++; if ({bus.resp_valid, bus.resp_err, bus.resp_data} !== {4'b1000, 1'b1, 16'd0}) begin n_fail++; $display("FAIL zero_both: resp %b err %b data %0d want 1000/1/0", bus.resp_valid, bus.resp_err, bus.resp_data); end
        n_checks++; if (bus.eng_start !== 1'b0) begin n_fail++; $display("FAIL zero_both_start: got %b want 0", bus.eng_start); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int  n;
        logic got;
        eng_en = 1'b0;
        set_ops(0, 16'd10, 16'd4);
        bus.req[0] = 1'b1;
        @(negedge clk);
        bus.req[0] = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.eng_data !== 16'd4) begin n_fail++; $display("FAIL tmo_data_b: got %0d want 4", bus.eng_data); end
        n = 0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            n++;
            if (bus.resp_valid != 4'b0) got = 1'b1;
        end
        n_checks++; if (n !== 16) begin n_fail++; $display("FAIL tmo_cycles: resp after %0d cycles want 16 (15 WAIT + RESP)", n); end
        n_checks++; if ({bus.resp_valid, bus.resp_err, bus.resp_data} !== {4'b0001, 1'b1, 16'd0}) begin n_fail++; $display("FAIL tmo_result: resp %b err %b data %0d want 0001/1/0", bus.resp_valid, bus.resp_err, bus.resp_data); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b want 0", busy); end
        eng_en = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        logic reached, saw_resp;
        set_ops(1, 16'd143, 16'd78);
        bus.req[1] = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 20 && !reached; c++) begin
            @(negedge clk);
            if (bus.ack[1]) bus.req[1] = 1'b0;
            if (dbg_state == ST_WAIT) reached = 1'b1;
        end
        n_checks++; if (reached !== 1'b1) begin n_fail++; $display("FAIL mid_reach_wait: WAIT not reached within 20 cycles"); end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.ack, bus.resp_valid, busy, bus.eng_start, bus.resp_err} !== 11'b0) begin n_fail++; $display("FAIL mid_flags: ack %b resp %b busy %b start %b err %b want 0", bus.ack, bus.resp_valid, busy, bus.eng_start, bus.resp_err); end
        n_checks++; if ({bus.eng_data, bus.resp_data} !== 32'h0) begin n_fail++; $display("FAIL mid_data: got %h want 0", {bus.eng_data, bus.resp_data}); end
        saw_resp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid != 4'b0) saw_resp = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid != 4'b0) saw_resp = 1'b1;
        end
        n_checks++; if (saw_resp !== 1'b0) begin n_fail++; $display("FAIL mid_no_resp: got resp_valid after reset want none"); end
        set_ops(0, 16'd9, 16'd6);
        set_ops(2, 16'd21, 16'd14);
        bus.req = 4'b0101;
        serve(2, 1'b0, 100);
        n_checks++; if (ack_log[0] !== 0 || ack_log[1] !== 2) begin n_fail++; $display("FAIL mid_ptr_order: got %0d,%0d want 0,2", ack_log[0], ack_log[1]); end
        n_checks++; if (rsp_dat[0] !== 16'd3 || rsp_dat[1] !== 16'd7 || n_rsp !== 2) begin n_fail++; $display("FAIL mid_results: got %0d,%0d (n=%0d) want 3,7 (n=2)", rsp_dat[0], rsp_dat[1], n_rsp); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        eng_en    = 1'b1;
        bus.req   = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_zero_bypass();
        test_timeout();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
